// File: rtl/tc_parade_multi_if.sv
`default_nettype none
// ============================================================================
// Module      : tc_parade_multi_if
// Description : Bundle of control inputs and light outputs for the
//               multi-direction parade traffic controller.
//               p           - parade request (sets parade mode)
//               r           - release (clears parade mode, wins over p)
//               t           - per-direction traffic sensors
//               l           - lights, 3 bits per direction (100 R, 010 Y, 001 G)
//               cur_dir     - direction owning the green/yellow phase
//               parade_mode - registered parade flag
// Revision    : 1.0 - initial release
// ============================================================================
interface tc_parade_multi_if #(
    parameter int N_DIR = 3,
    parameter int DIR_W = 2
);
    logic                 p;
    logic                 r;
    logic [N_DIR-1:0]     t;
    logic [3*N_DIR-1:0]   l;
    logic [DIR_W-1:0]     cur_dir;
    logic                 parade_mode;

    // Controller side
    modport slave (
        input  p,
        input  r,
        input  t,
        output l,
        output cur_dir,
        output parade_mode
    );

    // Environment side
    modport master (
        output p,
        output r,
        output t,
        input  l,
        input  cur_dir,
        input  parade_mode
    );
endinterface
`default_nettype wire

// File: rtl/tc_parade_multi.sv
`default_nettype none
// ============================================================================
// Module      : tc_parade_multi
// Description : N_DIR-direction traffic controller with round-robin green
//               arbitration on traffic sensors, minimum/maximum green time,
//               timed yellow, optional all-red clearance and a parade mode
//               that pins PARADE_DIR to green until released.
// Ports       : clk   - system clock, rising edge
//               rst_n - asynchronous active-low reset
//               bus   - tc_parade_multi_if.slave (p, r, t in; l, cur_dir,
//                       parade_mode out)
// Revision    : 1.0 - initial release
// ============================================================================
module tc_parade_multi #(
    parameter int N_DIR      = 3,
    parameter int DIR_W      = 2,
    parameter int CNT_W      = 8,
    parameter int GREEN_MIN  = 4,
    parameter int GREEN_MAX  = 8,
    parameter int YELLOW_CYC = 2,
    parameter int ALLRED_CYC = 1,
    parameter int PARADE_DIR = 1
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    tc_parade_multi_if.slave   bus
);

    typedef enum logic [1:0] {
        S_GREEN   = 2'd0,
        S_YELLOW  = 2'd1,
        S_ALL_RED = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] C_GMIN_LAST = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] C_GMAX_LAST = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] C_YEL_LAST  = CNT_W'(YELLOW_CYC - 1);
    localparam logic [CNT_W-1:0] C_AR_LAST   = CNT_W'((ALLRED_CYC > 0) ? (ALLRED_CYC - 1) : 0);
    localparam logic [DIR_W-1:0] C_PARADE    = DIR_W'(PARADE_DIR);

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [DIR_W-1:0]     r_dir;
    logic                 r_parade;
    logic [3*N_DIR-1:0]   r_lights;

    state_t               w_state_nxt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic [DIR_W-1:0]     w_dir_nxt;
    logic                 w_parade_nxt;
    logic [DIR_W-1:0]     w_scan_dir;
    logic                 w_scan_hit;
    logic [DIR_W-1:0]     w_next_green;
    logic [N_DIR-1:0]     w_cur_mask;
    logic                 w_other_req;
    logic                 w_green_exit;

    // (d + k) mod N_DIR for d < N_DIR and 0 < k < N_DIR
    function automatic logic [DIR_W-1:0] f_adv(input logic [DIR_W-1:0] d, input int k);
        logic [DIR_W:0] s;
        s = {1'b0, d} + (DIR_W+1)'(k);
        if (s >= (DIR_W+1)'(N_DIR)) begin
            s = s - (DIR_W+1)'(N_DIR);
        end
        return s[DIR_W-1:0];
    endfunction

    function automatic logic [3*N_DIR-1:0] f_lights(input state_t st, input logic [DIR_W-1:0] d);
        logic [3*N_DIR-1:0] v;
        for (int i = 0; i < N_DIR; i++) begin
            v[3*i +: 3] = 3'b100;
            if (st != S_ALL_RED && DIR_W'(i) == d) begin
                v[3*i +: 3] = (st == S_GREEN) ? 3'b001 : 3'b010;
            end
        end
        return v;
    endfunction

    // Round-robin scan: walk offsets from far to near so the nearest
    // requesting direction after the current one wins.
    always_comb begin
        w_scan_dir = '0;
        w_scan_hit = 1'b0;
        for (int k = N_DIR - 1; k >= 1; k--) begin
            if (bus.t[f_adv(r_dir, k)]) begin
                w_scan_hit = 1'b1;
                w_scan_dir = f_adv(r_dir, k);
            end
        end
    end

    assign w_next_green = r_parade   ? C_PARADE   :
                          w_scan_hit ? w_scan_dir : f_adv(r_dir, 1);

    assign w_cur_mask  = N_DIR'(1) << r_dir;
    assign w_other_req = |(bus.t & ~w_cur_mask);

    assign w_green_exit = (r_cnt >= C_GMIN_LAST) &&
                          (r_parade ? (r_dir != C_PARADE)
                                    : (!bus.t[r_dir] || (r_cnt == C_GMAX_LAST && w_other_req)));

    // Release has priority over a simultaneous parade request.
    assign w_parade_nxt = bus.r ? 1'b0 : (bus.p ? 1'b1 : r_parade);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_dir_nxt   = r_dir;
        case (r_state)
            S_GREEN: begin
                if (w_green_exit) begin
                    w_state_nxt = S_YELLOW;
                    w_cnt_nxt   = '0;
                end else if (r_cnt != C_GMAX_LAST) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_YELLOW: begin
                if (r_cnt == C_YEL_LAST) begin
                    w_cnt_nxt = '0;
                    if (ALLRED_CYC == 0) begin
                        w_state_nxt = S_GREEN;
                        w_dir_nxt   = w_next_green;
                    end else begin
                        w_state_nxt = S_ALL_RED;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_ALL_RED: begin
                if (r_cnt == C_AR_LAST) begin
                    w_state_nxt = S_GREEN;
                    w_dir_nxt   = w_next_green;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_GREEN;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Lights are registered from the next state so they change on the
    // same edge as the phase itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_GREEN;
            r_cnt    <= '0;
            r_dir    <= '0;
            r_parade <= 1'b0;
            r_lights <= f_lights(S_GREEN, '0);
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_dir    <= w_dir_nxt;
            r_parade <= w_parade_nxt;
            r_lights <= f_lights(w_state_nxt, w_dir_nxt);
        end
    end

    assign bus.l           = r_lights;
    assign bus.cur_dir     = r_dir;
    assign bus.parade_mode = r_parade;

endmodule
`default_nettype wire
